risc_mc_control: RTL

Multi-cycle main control FSM for the 16-bit RISC core. Sequences each instruction through fetch, decode, execute, memory and writeback over a shared memory port with a req/ack handshake. Drives the 2-bit ALUOp consumed by the ALU control decoder, the datapath mux selects and the register, PC and IR write strobes. Keeps a retired-instruction counter.

---
 rtl/risc_mc_control.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/risc_mc_control.sv
// Multi-cycle main control FSM for the 16-bit RISC core: sequences fetch, decode,
// execute, memory and writeback over a req/ack memory port and counts retired instructions.
module risc_mc_control #(
    parameter int CNT_W = 16,
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_e;

    localparam logic [1:0] ALU_ADD_FN = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_ADDR   = 2'b10;

    localparam logic [1:0] PC_SEQ     = 2'b00;
    localparam logic [1:0] PC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic op_lw, op_sw, op_r, op_beq, op_bne, op_jmp;
    logic taken;

    // The opcode doubles as the ALU function field, so R-type is a contiguous range.
    always_comb begin
        op_lw  = (opcode == OPC_W'(4'h0));
        op_sw  = (opcode == OPC_W'(4'h1));
        op_r   = (opcode >= OPC_W'(4'h2)) && (opcode <= OPC_W'(4'h9));
        op_beq = (opcode == OPC_W'(4'hB));
        op_bne = (opcode == OPC_W'(4'hC));
        op_jmp = (opcode == OPC_W'(4'hD));
        taken  = (op_beq & zero) | (op_bne & ~zero);
    end

    // NOTE: asynchronous reset lets a mid-transaction reset drop mem_req without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of ordering.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output and the next state get a default first so no path infers a latch.
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        alu_op     = ALU_ADD_FN;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SEQ;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_lw || op_sw) begin
                    state_d = S_ADDR;
                end else if (op_r) begin
                    state_d = S_EXEC;
                end else if (op_beq || op_bne) begin
                    state_d = S_BRANCH;
                end else if (op_jmp) begin
                    state_d = S_JUMP;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                alu_op  = ALU_ADD_FN;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                alu_op    = ALU_ADD_FN;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_IDLE;
            end
            S_ADDR: begin
                alu_op  = ALU_ADDR;
                alu_src = 1'b1;
                state_d = op_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                alu_op  = ALU_ADDR;
                alu_src = 1'b1;
                if (mem_ack) begin
                    state_d = S_WB_LD;
                end
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_IDLE;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                alu_op  = ALU_ADDR;
                alu_src = 1'b1;
                if (mem_ack) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BRANCH: begin
                alu_op  = ALU_SUB;
                retire  = 1'b1;
                state_d = S_IDLE;
                if (taken) begin
                    pc_write = 1'b1;
                    pc_src   = PC_BRANCH;
                end
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                retire   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running wrap: the counter is observational only and carries no overflow flag.
    always_comb begin
        cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    assign retired_cnt = cnt_q;
    assign state       = state_q;

endmodule
